muldiv_unit: RTL

Iterative RV32M multiply/divide unit for the multicycle RISC-V core, parametrised in data width. Sits beside the combinational ALU in the execute stage. It accepts one operation per start pulse and computes through a shift-add multiplier or a restoring divider over XLEN cycles. It returns the result with a one-cycle done pulse while the main control FSM stalls on Busy.

---
 rtl/DataTypes_pkg.sv | 30 +++
 rtl/muldiv_core.sv | 64 ++++++
 rtl/muldiv_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/DataTypes_pkg.sv
// Shared execute-stage operation encodings for the multicycle RISC-V core.
package DataTypes_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001,
    ALU_LUI  = 4'b1010
  } ALUop_t;

  // Encoding matches the RV32M funct3 field so decode can pass it straight through.
  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } MDUop_t;

endpackage

// File: rtl/muldiv_core.sv
// Unsigned iterative datapath: shift-add multiplier or restoring divider, one step per cycle.
module muldiv_core #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            last,
  output logic [XLEN-1:0] acc_hi,
  output logic [XLEN-1:0] acc_lo
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q;
  logic              is_div_q;
  logic [CNT_W-1:0]  count_q;

  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     shifted;
  logic [XLEN-1:0]   diff;
  logic              fits;

  // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff    = shifted[XLEN-1:0] - opnd_q;
    fits    = shifted >= {1'b0, opnd_q};
    acc_d   = acc_q;
    if (is_div_q) begin
      if (fits) acc_d = {diff, acc_q[XLEN-2:0], 1'b1};
      else      acc_d = {shifted[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      acc_d = {add_sum, acc_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      count_q  <= '0;
    end else if (load) begin
      acc_q    <= {{XLEN{1'b0}}, (is_div ? op_a : op_b)};
      opnd_q   <= is_div ? op_b : op_a;
      is_div_q <= is_div;
      count_q  <= '0;
    end else if (step) begin
      acc_q    <= acc_d;
      count_q  <= count_q + 1'b1;
    end
  end

  assign last   = (count_q == CNT_W'(XLEN - 1));
  assign acc_hi = acc_q[2*XLEN-1:XLEN];
  assign acc_lo = acc_q[XLEN-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: sign handling, special cases and control around muldiv_core.
module muldiv_unit
  import DataTypes_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start,
  input  MDUop_t          MDUControl,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] MDUResult
);

  typedef enum logic [1:0] {StIdle, StBusy, StFix, StDone} state_t;

  state_t          state_q, state_d;
  MDUop_t          op_q;
  logic            neg_q;
  logic [XLEN-1:0] result_q;

  logic            a_signed, b_signed, sign_a, sign_b, neg_d;
  logic            is_div, is_rem, div_zero, overflow, special;
  logic [XLEN-1:0] abs_a, abs_b, special_res;
  logic            accept, core_load, core_step, core_last;
  logic [XLEN-1:0] acc_hi, acc_lo, qr_raw, qr_fix, fix_res;
  logic [2*XLEN-1:0] prod_fix;

  // Operand decode and sign capture.
  always_comb begin
    a_signed = (MDUControl == MDU_MUL) || (MDUControl == MDU_MULH) ||
               (MDUControl == MDU_MULHSU) || (MDUControl == MDU_DIV) ||
               (MDUControl == MDU_REM);
    b_signed = (MDUControl == MDU_MUL) || (MDUControl == MDU_MULH) ||
               (MDUControl == MDU_DIV) || (MDUControl == MDU_REM);
    sign_a   = a_signed & SrcA[XLEN-1];
    sign_b   = b_signed & SrcB[XLEN-1];
    abs_a    = sign_a ? (~SrcA + 1'b1) : SrcA;
    abs_b    = sign_b ? (~SrcB + 1'b1) : SrcB;
    is_div   = MDUControl[2];
    is_rem   = MDUControl[2] & MDUControl[1];
    neg_d    = is_rem ? sign_a : (sign_a ^ sign_b);
  end

  // Cases RV32M defines without a trap; answered at accept with no iteration.
  always_comb begin
    div_zero = is_div && (SrcB == '0);
    overflow = ((MDUControl == MDU_DIV) || (MDUControl == MDU_REM)) &&
               (SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (SrcB == '1);
    special  = div_zero || overflow;
    if (div_zero) special_res = is_rem ? SrcA : '1;
    else          special_res = is_rem ? '0 : SrcA;
  end

  assign accept    = (state_q == StIdle) && Start;
  assign core_load = accept && !special;
  assign core_step = (state_q == StBusy);

  muldiv_core #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (core_load),
    .step   (core_step),
    .is_div (is_div),
    .op_a   (abs_a),
    .op_b   (abs_b),
    .last   (core_last),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo)
  );

  // Multiply negates the full product before selecting a half; divide negates the chosen word.
  always_comb begin
    prod_fix = neg_q ? (~{acc_hi, acc_lo} + 1'b1) : {acc_hi, acc_lo};
    qr_raw   = op_q[1] ? acc_hi : acc_lo;
    qr_fix   = neg_q ? (~qr_raw + 1'b1) : qr_raw;
    if (op_q[2])              fix_res = qr_fix;
    else if (op_q == MDU_MUL) fix_res = prod_fix[XLEN-1:0];
    else                      fix_res = prod_fix[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (Start) state_d = special ? StDone : StBusy;
      StBusy: if (core_last) state_d = StFix;
      StFix:  state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= MDU_MUL;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= MDUControl;
        neg_q <= neg_d;
        if (special) result_q <= special_res;
      end
      if (state_q == StFix) result_q <= fix_res;
    end
  end

  assign Busy      = (state_q != StIdle);
  assign Done      = (state_q == StDone);
  assign MDUResult = result_q;

endmodule
